// File: rtl/button_conditioner.sv
// Two-flop (or deeper) synchronizer followed by a symmetric counting debouncer.
// Output level, rise and fall pulses are all registered.
module button_conditioner #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic out,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   // Initial values give a clean power-up when rst is tied low.
   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q = '0;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [CNT_W-1:0]       cnt_q = '0;
   logic [CNT_W-1:0]       cnt_d;
   logic                   out_q  = 1'b0;
   logic                   out_d;
   logic                   rise_q = 1'b0;
   logic                   rise_d;
   logic                   fall_q = 1'b0;
   logic                   fall_d;
   logic                   btn_sync;

   assign btn_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      sync_d = {sync_q[SYNC_STAGES-2:0], btn};
      cnt_d  = cnt_q;
      out_d  = out_q;

      if (btn_sync == out_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         out_d = btn_sync;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         cnt_q  <= '0;
         out_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values; the sync chain depends on it.
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign out  = out_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: stimulus pushes expected edge events into a
// scoreboard queue; a negedge monitor pops and checks each rise/fall pulse.
module tb_button_conditioner;

   localparam int SYNC_STAGES   = 2;
   localparam int STABLE_CYCLES = 8;
   localparam int LAT           = SYNC_STAGES + STABLE_CYCLES;

   typedef enum logic {EV_RISE, EV_FALL} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn = 1'b0;
   logic out;
   logic rise;
   logic fall;

   int   cyc      = 0;
   int   n_checks = 0;
   int   n_err    = 0;
   ev_t  exp_q[$];

   button_conditioner #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .btn (btn),
      .out (out),
      .rise(rise),
      .fall(fall)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every edge pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rise || fall) begin
         check(!(rise && fall), "pulse_exclusive", {30'd0, rise, fall}, 0);
         check(exp_q.size() != 0, "pulse_expected", {30'd0, rise, fall}, 0);
         if (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            check(rise == (e.kind == EV_RISE), "pulse_kind", int'(rise), int'(e.kind == EV_RISE));
            check(e.cyc == cyc, "pulse_cycle", cyc, e.cyc);
            check(out == rise, "pulse_out_level", int'(out), int'(rise));
         end
      end
   end

   // Drive btn at a negedge and expect the matching out edge LAT edges later.
   task automatic drive_expect(input logic v);
      ev_t e;
      btn    = v;
      e.kind = v ? EV_RISE : EV_FALL;
      e.cyc  = cyc + LAT;
      exp_q.push_back(e);
   endtask

   // Out must hold its old value up to the edge before the change, then switch.
   task automatic expect_change(input logic old_v, input string name);
      repeat (LAT - 1) @(negedge clk);
      check(out == old_v, {name, "_early"}, int'(out), int'(old_v));
      @(negedge clk);
      check(out == !old_v, {name, "_out"}, int'(out), int'(!old_v));
   endtask

   task automatic hold(input logic v, input int n);
      btn = v;
      repeat (n) begin
         @(negedge clk);
         check(out == 1'b0, "bounce_hold", int'(out), 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Power-up idle with rst tied low.
      repeat (50) begin
         @(negedge clk);
         check({out, rise, fall} == 3'b000, "idle", {29'd0, out, rise, fall}, 0);
      end

      // Clean press.
      drive_expect(1'b1);
      expect_change(1'b0, "press");
      repeat (5) @(negedge clk);

      // Clean release.
      drive_expect(1'b0);
      expect_change(1'b1, "release");
      repeat (5) @(negedge clk);

      // Bounce: runs of 5/2/7/3 never reach the threshold.
      hold(1'b1, 5);
      hold(1'b0, 2);
      hold(1'b1, 7);
      hold(1'b0, 3);
      drive_expect(1'b1);
      expect_change(1'b0, "bounce");
      repeat (5) @(negedge clk);
      drive_expect(1'b0);
      expect_change(1'b1, "bounce_release");
      repeat (5) @(negedge clk);

      // Asynchronous reset at count 5 discards the count.
      btn = 1'b1;
      repeat (7) @(negedge clk);
      #2 rst = 1'b1;
      #1 check({out, rise, fall} == 3'b000, "rst_mid_async", {29'd0, out, rise, fall}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      begin
         ev_t e;
         e.kind = EV_RISE;
         e.cyc  = cyc + LAT;
         exp_q.push_back(e);
      end
      expect_change(1'b0, "rst_mid_restart");
      repeat (3) @(negedge clk);

      // Reset while out is high: immediate drop, no fall pulse.
      #2 rst = 1'b1;
      #1 check({out, rise, fall} == 3'b000, "rst_high_async", {29'd0, out, rise, fall}, 0);
      repeat (2) @(negedge clk);
      check(out == 1'b0, "rst_high_held", int'(out), 0);
      rst = 1'b0;
      begin
         ev_t e;
         e.kind = EV_RISE;
         e.cyc  = cyc + LAT;
         exp_q.push_back(e);
      end
      expect_change(1'b0, "rst_high_restart");
      repeat (5) @(negedge clk);

      check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
